// File: rtl/inv_pipe.sv
`default_nettype none
// ============================================================================
// Module      : inv_pipe
// Description : Elastic DEPTH-stage valid/ready pipeline. It applies a
//               per-word transform (pass / NOT / masked NOT / zero) as the
//               word enters, and keeps a saturating count of delivered words.
//               Optional macro: SWITCH_LEVEL_INV_EN builds the inverters from
//               pmos/nmos switch primitives.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [1:0] C_MODE_PASS = 2'b00;
    localparam logic [1:0] C_MODE_NOT  = 2'b01;
    localparam logic [1:0] C_MODE_MASK = 2'b10;

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CNT_W-1:0] r_cnt;
    logic [DEPTH-1:0] w_rdy;
    logic [WIDTH-1:0] w_xf;
    wire  [WIDTH-1:0] w_not;
    wire  [WIDTH-1:0] w_mskd;

`ifdef SWITCH_LEVEL_INV_EN
    supply1 vdd;
    supply0 gnd;

    // CMOS inverter per bit, then a complementary switch pair steers either
    // the inverted or the original bit through according to in_mask.
    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_sw_inv
            pmos u_inv_p (w_not[g], vdd, in_data[g]);
            nmos u_inv_n (w_not[g], gnd, in_data[g]);
            nmos u_sel_n (w_mskd[g], w_not[g], in_mask[g]);
            pmos u_sel_p (w_mskd[g], in_data[g], in_mask[g]);
        end
    endgenerate
`else
    assign w_not  = ~in_data;
    assign w_mskd = in_data ^ in_mask;
`endif

    always_comb begin
        w_xf = '0;
        case (in_mode)
            C_MODE_PASS: w_xf = in_data;
            C_MODE_NOT:  w_xf = w_not;
            C_MODE_MASK: w_xf = w_mskd;
            default:     w_xf = '0;
        endcase
    end

    // Ready ripples back from the consumer: a stage can move if the next one
    // is empty or is itself moving this cycle.
    always_comb begin
        w_rdy = '0;
        w_rdy[DEPTH-1] = out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_rdy[i] = !r_v[i+1] || w_rdy[i+1];
        end
    end

    assign in_ready  = !r_v[0] || w_rdy[0];
    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign out_count = r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            if (in_ready) begin
                r_v[0] <= in_valid;
                if (in_valid) begin
                    r_d[0] <= w_xf;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (!r_v[i] || w_rdy[i]) begin
                    r_v[i] <= r_v[i-1];
                    if (r_v[i-1]) begin
                        r_d[i] <= r_d[i-1];
                    end
                end
            end
            if (r_v[DEPTH-1] && out_ready && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inv_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_pipe
// Description : Self-checking bench for inv_pipe using a vector table and an
//               expected-word queue, plus a CNT_W=4 instance for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_pipe;

    typedef struct {
        logic [7:0] d;
        logic [1:0] m;
        logic [7:0] k;
        logic [7:0] e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_data, in_mask, out_data;
    logic [1:0]  in_mode;
    logic [15:0] out_count;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0]  in_data4, out_data4;
    logic [3:0]  out_count4;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  m_exp;
    logic        done;

    always #5 clk = ~clk;

    inv_pipe #(.WIDTH(8), .DEPTH(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count)
    );

    inv_pipe #(.WIDTH(8), .DEPTH(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .in_mode(2'b00), .in_mask(8'h00),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_count(out_count4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic [1:0] m, input logic [7:0] k);
        case (m)
            2'b00:   return d;
            2'b01:   return ~d;
            2'b10:   return d ^ k;
            default: return 8'h00;
        endcase
    endfunction

    // Handshakes are judged mid-cycle; they take effect on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got 0x%0h, required no output", out_data);
            end else begin
                m_exp = exp_q.pop_front();
                check("out_data", {24'h0, out_data}, {24'h0, m_exp});
            end
        end
    end

    // Called and returns at posedge+1; offers one word until it is accepted.
    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [7:0] k, input logic [7:0] e);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_mode = m; in_mask = k;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (in_ready) exp_q.push_back(e);
        else check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   lat, acc, dl;
        logic seen, chk15;

        vecs[0] = '{8'hA5, 2'b01, 8'h00, 8'h5A};
        vecs[1] = '{8'hF0, 2'b10, 8'h3C, 8'hCC};
        vecs[2] = '{8'h81, 2'b00, 8'hFF, 8'h81};
        vecs[3] = '{8'hFF, 2'b11, 8'h00, 8'h00};
        vecs[4] = '{8'h00, 2'b01, 8'h00, 8'hFF};
        vecs[5] = '{8'h55, 2'b10, 8'hFF, 8'hAA};
        vecs[6] = '{8'h3C, 2'b10, 8'h00, 8'h3C};
        vecs[7] = '{8'h12, 2'b11, 8'hFF, 8'h00};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_mask = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1; done = 1'b0;

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data), 0);
        check("rst_out_count", 32'(out_count), 0);
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 1);

        // Latency: accept edge counts as the first of DEPTH edges
        send(8'hA5, 2'b01, 8'h00, 8'h5A);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 3);
        check("lat_data", 32'(out_data), 32'h5A);
        @(posedge clk); #1;
        check("count_1", 32'(out_count), 1);

        // Table vectors, back to back
        for (int i = 0; i < 8; i++) send(vecs[i].d, vecs[i].m, vecs[i].k, vecs[i].e);
        drain("drain_table");
        check("count_9", 32'(out_count), 9);

        // Fill with back-pressure
        out_ready = 1'b0;
        send(8'h11, 2'b01, 8'h00, 8'hEE);
        send(8'h22, 2'b01, 8'h00, 8'hDD);
        send(8'h33, 2'b01, 8'h00, 8'hCC);
        in_valid = 1'b1; in_data = 8'h44; in_mode = 2'b01;
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_out_valid", 32'(out_valid), 1);
        @(posedge clk); #1;
        check("stall_hold", 32'(out_data), 32'hEE);
        check("stall_count", 32'(out_count), 9);
        out_ready = 1'b1;
        send(8'h44, 2'b01, 8'h00, 8'hBB);
        drain("drain_full");
        check("count_13", 32'(out_count), 13);

        // Random traffic
        do_reset();
        fork
            begin
                for (int w = 0; w < 1000; w++) begin
                    logic [7:0] d, k;
                    logic [1:0] m;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    d = 8'($urandom); k = 8'($urandom); m = 2'($urandom);
                    send(d, m, k, model(d, m, k));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_random");
        check("count_1000", 32'(out_count), 1000);

        // Reset with words in flight
        out_ready = 1'b0;
        send(8'h01, 2'b00, 8'h00, 8'h01);
        send(8'h02, 2'b00, 8'h00, 8'h02);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_count", 32'(out_count), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("no_stale", 32'(seen), 0);

        // Saturating counter on the CNT_W=4 instance
        acc = 0; dl = 0; chk15 = 1'b0;
        in_valid4 = 1'b1;
        for (int c = 0; c < 100 && dl < 20; c++) begin
            in_data4 = 8'(acc);
            @(negedge clk);
            if (in_valid4 && in_ready4) acc++;
            if (out_valid4 && out_ready4) dl++;
            @(posedge clk); #1;
            if (acc >= 20) in_valid4 = 1'b0;
            if (dl == 15 && !chk15) begin
                check("cnt4_at_15", 32'(out_count4), 15);
                chk15 = 1'b1;
            end
        end
        repeat (5) begin @(posedge clk); #1; end
        check("cnt4_delivered", dl, 20);
        check("cnt4_saturated", 32'(out_count4), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
